// File: rtl/arbiter_rr_hold_if.sv
// Request/grant bus between requesting masters and the round-robin arbiter.
// req is level-sensitive from the masters. gnt, gnt_valid, gnt_id and hold_cnt are registered by the arbiter, and a grant seen in cycle t+1 answers req sampled in cycle t.
interface arbiter_rr_hold_if #(
    parameter int N    = 5,
    parameter int ID_W = 3,
    parameter int HC_W = 3
);
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [ID_W-1:0] gnt_id;
    logic [HC_W-1:0] hold_cnt;

    modport master (output req, input gnt, input gnt_valid, input gnt_id, input hold_cnt);
    modport slave  (input req, output gnt, output gnt_valid, output gnt_id, output hold_cnt);
endinterface

// File: rtl/arbiter_rr_hold.sv
// Round-robin arbiter with registered one-hot grants and a bounded hold.
// An owner may keep its grant for MAX_HOLD cycles while anyone else is waiting.
module arbiter_rr_hold #(
    parameter int N        = 5,
    parameter int MAX_HOLD = 4,
    parameter int ID_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    arbiter_rr_hold_if.slave  bus,
    output logic              dbg_state
);
    localparam int HC_W = $clog2(MAX_HOLD) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [HC_W-1:0] hold_q, hold_d;

    logic [N-1:0]    own_mask;
    logic            keep;
    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        gnt_d    = gnt_q;
        hold_d   = hold_q;
        found    = 1'b0;
        idx      = ptr_q;
        own_mask = N'(1) << ptr_q;
        keep     = (state_q == GRANT) && (|(bus.req & own_mask)) &&
                   ((hold_q < HC_W'(MAX_HOLD)) || !(|(bus.req & ~own_mask)));

        if (keep) begin
            if (hold_q < HC_W'(MAX_HOLD)) begin
                hold_d = hold_q + HC_W'(1);
            end
        end else if (!(|bus.req)) begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
        end else begin
            // Walk from ptr+1 and finish on ptr itself, so an owner whose hold expired loses to anyone else.
            for (int k = 0; k < N; k++) begin
                idx = (idx == ID_W'(N - 1)) ? '0 : idx + ID_W'(1);
                if (!found && bus.req[idx]) begin
                    found   = 1'b1;
                    state_d = GRANT;
                    ptr_d   = idx;
                    id_d    = idx;
                    gnt_d   = N'(1) << idx;
                    hold_d  = HC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(N - 1);
            id_q    <= '0;
            gnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = (state_q == GRANT);
    assign bus.gnt_id    = id_q;
    assign bus.hold_cnt  = hold_q;
    assign dbg_state     = state_q;
endmodule
